cpu_req_master: RTL and testbench

CPU_REQ_MASTER -- requirements
Module: cpu_req_master

---
 rtl/cpu_req_master.sv | 197 +++++++++++++++++++
 tb/tb_cpu_req_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_req_master.sv
// cpu_req_master: queues CPU read/write commands in a small FIFO and issues them to the cache one at a time, in order.
// Latency: 1 cycle to issue, then the cache wait, then 1 cycle DONE pulse; at least one idle-valid cycle between requests.
// Backpressure: cmd_ready drops when the FIFO is full. Optional macro CPU_REQ_TIMEOUT_EN aborts a request stuck in REQ.

package cpu_req_pkg;
  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        valid;
  } cpu_to_cache_type;

  typedef struct packed {
    logic [15:0] data;
    logic        ready;
  } cache_to_cpu_type;
endpackage

module cpu_req_master
  import cpu_req_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [19:0]      cmd_addr,
  input  logic [15:0]      cmd_data,
  output cpu_to_cache_type cpu_to_cache,
  input  cache_to_cpu_type cache_to_cpu,
  output logic             rsp_valid,
  output logic             rsp_rw,
  output logic [19:0]      rsp_addr,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             timeout_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 37;  // {rw, addr[19:0], data[15:0]}

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, fifo_empty;
  logic [EW-1:0]    head;
  logic             cache_ack, timeout_hit, req_end;
  cpu_to_cache_type req_q;
  logic             rsp_rw_q;
  logic [19:0]      rsp_addr_q;
  logic [15:0]      rsp_data_q;

  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign head       = mem_q[rd_ptr_q];
  // ready only counts while a request is actually outstanding
  assign cache_ack  = (state_q == ST_REQ) & cache_to_cpu.ready;
  assign req_end    = cache_ack | timeout_hit;

  // FIFO storage; not reset because occupancy is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_rw, cmd_addr, cmd_data};
  end

  // Occupancy next-state: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ:  if (req_end)     state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: pop the head when idle, pulse the response in DONE
  always_comb begin
    pop       = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: pop       = !fifo_empty;
      ST_DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request registers: loaded on pop, held through REQ, valid dropped when the request ends
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (pop) begin
      req_q.rw    <= head[36];
      req_q.addr  <= head[35:16];
      req_q.data  <= head[15:0];
      req_q.valid <= 1'b1;
    end else if (req_end) begin
      req_q.valid <= 1'b0;
    end
  end

  assign cpu_to_cache = req_q;

  // Response registers: captured as the request ends, held until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rw_q   <= 1'b0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else if (req_end) begin
      rsp_rw_q   <= req_q.rw;
      rsp_addr_q <= req_q.addr;
      rsp_data_q <= (cache_ack && !req_q.rw) ? cache_to_cpu.data : 16'h0;
    end
  end

  assign rsp_rw   = rsp_rw_q;
  assign rsp_addr = rsp_addr_q;
  assign rsp_data = rsp_data_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);

`ifdef CPU_REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt_q;
  logic          rsp_err_q, timeout_err_q;

  // Abort on the last allowed REQ cycle; a ready in that same cycle still wins
  assign timeout_hit = (state_q == ST_REQ) && !cache_to_cpu.ready &&
                       (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count REQ cycles; restarted whenever a new request is loaded
  always_ff @(posedge clk) begin
    if (rst)                              tmo_cnt_q <= '0;
    else if (pop)                         tmo_cnt_q <= '0;
    else if (state_q == ST_REQ && !req_end) tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end

  // Per-response abort flag and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (req_end)     rsp_err_q     <= timeout_hit;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign rsp_err     = rsp_err_q;
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
  assign rsp_err            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_req_master.sv
// Randomized bench for cpu_req_master with a cache responder, an in-order reference model and scoreboards.
// Expected responses are computed from a simple word-memory model at command acceptance.
// Monitors compare issued requests and completions independently of the stimulus process.
module tb_cpu_req_master;
  import cpu_req_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
`ifdef CPU_REQ_TIMEOUT_EN
  localparam int LONG_WAIT = 12;
`else
  localparam int LONG_WAIT = 60;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid, cmd_ready, cmd_rw;
  logic [19:0]      cmd_addr;
  logic [15:0]      cmd_data;
  cpu_to_cache_type cpu_to_cache;
  cache_to_cpu_type cache_to_cpu;
  logic             rsp_valid, rsp_rw, rsp_err, busy, timeout_err;
  logic [19:0]      rsp_addr;
  logic [15:0]      rsp_data;

  cpu_req_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cpu_to_cache(cpu_to_cache), .cache_to_cpu(cache_to_cpu),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic rw; logic [19:0] addr; logic [15:0] data; logic err; } exp_t;
  typedef struct { logic rw; logic [19:0] addr; logic [15:0] data; } iss_t;

  exp_t        exp_q[$];
  iss_t        iss_q[$];
  logic [15:0] ref_mem [int];
  logic [15:0] cache_mem [int];
  int          checks = 0;
  int          errors = 0;
  int          rsp_cnt = 0;
  logic        stall = 1'b0;
  int          max_wait = 5;
  int          force_wait = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Offer one command from a negedge; on acceptance record the expected issue and response.
  task automatic send(input logic rw, input logic [19:0] addr, input logic [15:0] data, input logic err);
    exp_t e;
    iss_t s;
    int   n;
    n = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_data = data;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 1, 0);
      cmd_valid = 1'b0;
      return;
    end
    e.rw = rw; e.addr = addr; e.err = err;
    if (rw || err) e.data = 16'h0;
    else           e.data = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0;
    if (rw && !err) ref_mem[int'(addr)] = data;
    exp_q.push_back(e);
    s.rw = rw; s.addr = addr; s.data = data;
    iss_q.push_back(s);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 4000) begin @(negedge clk); n++; end
    chk("drain_timeout", (exp_q.size() != 0 || busy), 0);
  endtask

  // Cache responder: random wait per request, ready noise while valid is low
  initial begin : cache_model
    int   wait_cnt;
    logic pv, ack_pend;
    cache_to_cpu = '0; wait_cnt = 0; pv = 1'b0; ack_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_pend) begin
        chk("valid_gap_after_ack", cpu_to_cache.valid, 0);
        ack_pend = 1'b0;
      end
      if (cpu_to_cache.valid) begin
        if (!pv) wait_cnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, max_wait));
        if (stall) begin
          cache_to_cpu.ready = 1'b0;
          wait_cnt = 0;
        end else if (wait_cnt == 0) begin
          cache_to_cpu.ready = 1'b1;
          if (cpu_to_cache.rw) begin
            cache_mem[int'(cpu_to_cache.addr)] = cpu_to_cache.data;
            cache_to_cpu.data = 16'($urandom);
          end else begin
            cache_to_cpu.data = cache_mem.exists(int'(cpu_to_cache.addr)) ?
                                cache_mem[int'(cpu_to_cache.addr)] : 16'h0;
          end
          ack_pend = 1'b1;
        end else begin
          cache_to_cpu.ready = 1'b0;
          wait_cnt--;
        end
      end else begin
        cache_to_cpu.ready = 1'($urandom_range(0, 1));
        cache_to_cpu.data  = 16'($urandom);
      end
      pv = cpu_to_cache.valid;
    end
  end

  // Request monitor: issue order and field stability while valid is high
  initial begin : mon_req
    iss_t        s;
    logic        pv;
    logic [36:0] cur;
    pv = 1'b0; cur = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (cpu_to_cache.valid && !pv) begin
          if (iss_q.size() == 0) begin
            chk("issue_unexpected", 1, 0);
          end else begin
            s = iss_q.pop_front();
            chk("issue_rw", cpu_to_cache.rw, s.rw);
            chk("issue_addr", cpu_to_cache.addr, s.addr);
            if (s.rw) chk("issue_wdata", cpu_to_cache.data, s.data);
          end
          cur = {cpu_to_cache.addr, cpu_to_cache.data, cpu_to_cache.rw};
        end else if (cpu_to_cache.valid) begin
          chk("req_stable", {cpu_to_cache.addr, cpu_to_cache.data, cpu_to_cache.rw}, cur);
        end
        pv = cpu_to_cache.valid;
      end
    end
  end

  // Response scoreboard: pops the expected response on every rsp_valid pulse
  initial begin : mon_rsp
    exp_t e, last;
    logic prv;
    last = '{default: '0}; prv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        last = '{default: '0};
        prv  = 1'b0;
      end else begin
        if (rsp_valid) begin
          rsp_cnt++;
          chk("rsp_single_pulse", prv, 0);
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rw", rsp_rw, e.rw);
            chk("rsp_addr", rsp_addr, e.addr);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            last = e;
          end
        end else begin
          chk("rsp_hold", {rsp_rw, rsp_addr, rsp_data, rsp_err},
              {last.rw, last.addr, last.data, last.err});
        end
        prv = rsp_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, n;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_to_cache", cpu_to_cache, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_rw, rsp_addr, rsp_data, rsp_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Back-to-back writes, then read them back
    c0 = rsp_cnt;
    send(1'b1, 20'h00000, 16'h0001, 1'b0);
    send(1'b1, 20'h00001, 16'h0002, 1'b0);
    drain();
    chk("two_write_rsp_pulses", rsp_cnt - c0, 2);
    send(1'b0, 20'h00000, 16'h0000, 1'b0);
    send(1'b0, 20'h00001, 16'h0000, 1'b0);
    drain();

    // Write to the aliasing address, then a read with a long cache wait
    send(1'b1, 20'h80000, 16'h0005, 1'b0);
    drain();
    force_wait = LONG_WAIT;
    send(1'b0, 20'h00000, 16'h0000, 1'b0);
    drain();
    force_wait = -1;

    // Fill the FIFO with the cache stalled: one issued plus DEPTH queued
    stall = 1'b1;
    @(negedge clk);
    c0 = rsp_cnt;
    for (int i = 0; i < DEPTH + 1; i++) send(1'b1, 20'h10 + 20'(i), 16'hA0 + 16'(i), 1'b0);
    chk("cmd_ready_full", cmd_ready, 0);
    chk("busy_full", busy, 1);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 20'h1F; cmd_data = 16'hDEAD;
    repeat (3) begin
      @(negedge clk);
      chk("full_no_accept", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    stall = 1'b0;
    drain();
    chk("full_all_completed", rsp_cnt - c0, DEPTH + 1);

    // Randomized traffic over a small address set so reads hit earlier writes
    for (int i = 0; i < 150; i++) begin
      logic [19:0] a;
      a = 20'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a[19] = 1'b1;
      send(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

`ifdef CPU_REQ_TIMEOUT_EN
    stall = 1'b1;
    @(negedge clk);
    send(1'b0, 20'h00123, 16'h0000, 1'b1);
    n = 0;
    while (!cpu_to_cache.valid && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (cpu_to_cache.valid && n < 100) begin @(negedge clk); n++; end
    chk("timeout_valid_cycles", n, TMO);
    drain();
    chk("timeout_err_set", timeout_err, 1);
    stall = 1'b0;
    send(1'b1, 20'h00124, 16'h0077, 1'b0);
    drain();
    chk("timeout_err_sticky", timeout_err, 1);
`else
    chk("timeout_err_off", timeout_err, 0);
`endif

    // Reset in the middle of a request with two commands queued
    stall = 1'b1;
    @(negedge clk);
    send(1'b0, 20'h00002, 16'h0000, 1'b0);
    send(1'b0, 20'h00003, 16'h0000, 1'b0);
    send(1'b0, 20'h00004, 16'h0000, 1'b0);
    chk("valid_before_rst", cpu_to_cache.valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", cpu_to_cache.valid, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_timeout_err", timeout_err, 0);
    exp_q.delete();
    iss_q.delete();
    stall = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("postrst_idle", {busy, cpu_to_cache.valid}, 0);
    send(1'b0, 20'h80000, 16'h0000, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
